misao_mem_responder: RTL and testbench

- Memory-side responder for the MISA-O CPU byte bus; it is the target that answers the core's mem_enable_read/mem_enable_write/mem_addr traffic.
- Holds a byte-wide synchronous RAM that is zero-filled after reset.
- Accepts a program image over a valid/ready loader port, then releases the core through boot_done.
- Sits between the misao core and the system loader (bench, boot ROM streamer or UART loader).

---
 rtl/misao_mem_pkg.sv | 19 +
 rtl/misao_mem_ram.sv | 33 +++
 rtl/misao_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_misao_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the MISA-O memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package misao_mem_pkg;

  localparam int MISAO_AW = 15;
  localparam int BYTE_W   = 8;

  // Value written by the post-reset clear sweep.
  localparam logic [BYTE_W-1:0] MEM_FILL = 8'h00;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } state_e;

endpackage

// File: rtl/misao_mem_ram.sv
// Byte-wide single-clock RAM, one write port and one registered read port.
// Latency: read data valid one cycle after re_i; write commits at the edge.
// Backpressure: none; a same-address read and write return the old byte.
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request;
//        rdata_o registered read data (holds when re_i is low).
module misao_mem_ram
  import misao_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] rdata_q;

  // Both ports update with non-blocking assignments, so a read sees the
  // contents from before a write at the same edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/misao_mem_responder.sv
// Memory responder for the MISA-O byte bus: clear sweep, image load, then CPU service.
// Latency: CPU read data one cycle after the strobe; writes commit at the strobe edge.
// Backpressure: loader held off (load_ready=0) outside LOAD; the CPU is never stalled.
// Ports: clk, rst (sync, active low); CPU bus mem_enable_read/mem_enable_write/
//        mem_rw/mem_addr/mem_data_out -> mem_data_in; loader load_valid/load_ready/
//        load_addr/load_data/load_last; status boot_done, err_oob, err_proto.
// Optional: define MISAO_MEM_TRACE_EN to add wr_count and a per-write trace print.
module misao_mem_responder
  import misao_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int AW        = MISAO_AW,
  parameter int LAST_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable_read,
  input  logic              mem_enable_write,
  input  logic              mem_rw,
  input  logic [AW-1:0]     mem_addr,
  input  logic [BYTE_W-1:0] mem_data_out,
  output logic [BYTE_W-1:0] mem_data_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [AW-1:0]     load_addr,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_last,
  output logic              boot_done,
  output logic              err_oob,
  output logic              err_proto
`ifdef MISAO_MEM_TRACE_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] CLR_LAST   = IW'(DEPTH - 1);
  localparam logic [3:0]    DRAIN_LAST = (LAST_WAIT == 0) ? 4'd0 : 4'(LAST_WAIT - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic              rd_zero_q, rd_zero_d;
  logic              err_oob_q, err_oob_d;
  logic              err_proto_q, err_proto_d;

  logic              ram_we;
  logic [IW-1:0]     ram_waddr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [BYTE_W-1:0] ram_rdata;
  logic              in_range, run, cpu_rd, cpu_wr;

  // Loader addresses wrap modulo DEPTH, so their upper bits are don't-care.
  logic unused_load_addr;
  assign unused_load_addr = ^load_addr;

  assign in_range = (32'(mem_addr) < DEPTH);
  assign run      = (state_q == ST_RUN);
  assign cpu_rd   = run && mem_enable_read  && in_range;
  assign cpu_wr   = run && mem_enable_write && in_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      drain_cnt_q <= '0;
      rd_zero_q   <= 1'b1;
      err_oob_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_zero_q   <= rd_zero_d;
      err_oob_q   <= err_oob_d;
      err_proto_q <= err_proto_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_zero_d   = rd_zero_q;
    err_oob_d   = err_oob_q;
    err_proto_d = err_proto_q;
    ram_we      = 1'b0;
    ram_waddr   = mem_addr[IW-1:0];
    ram_wdata   = mem_data_out;
    load_ready  = 1'b0;
    boot_done   = 1'b0;

    // Any read strobe picks the next mem_data_in source: RAM for a serviced
    // read, forced zero for out-of-range or pre-RUN reads. No strobe holds it.
    if (mem_enable_read) rd_zero_d = !cpu_rd;

    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = MEM_FILL;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_waddr = load_addr[IW-1:0];
          ram_wdata = load_data;
          if (load_last) begin
            drain_cnt_d = '0;
            state_d     = (LAST_WAIT == 0) ? ST_RUN : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        boot_done = 1'b1;
        ram_we    = cpu_wr;
        if ((mem_enable_read || mem_enable_write) && !in_range) err_oob_d = 1'b1;
        if ((mem_enable_write && !mem_rw) ||
            (mem_enable_read && mem_rw && !mem_enable_write)) err_proto_d = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  misao_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (cpu_rd),
    .raddr_i (mem_addr[IW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign mem_data_in = rd_zero_q ? '0 : ram_rdata;
  assign err_oob     = err_oob_q;
  assign err_proto   = err_proto_q;

`ifdef MISAO_MEM_TRACE_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst) wr_count_q <= '0;
    else if (cpu_wr && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
  end

  assign wr_count = wr_count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && cpu_wr) $display("MEM[%02h] <- %02h", mem_addr[IW-1:0], mem_data_out);
  end
`endif
`endif

endmodule

// File: tb/tb_misao_mem_responder.sv
// Directed bench for misao_mem_responder (DEPTH=256, LAST_WAIT=0).
// Latency: checks read data one cycle after each strobe.
// Backpressure: drives the loader only while load_ready is high.
module tb_misao_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_read, mem_enable_write, mem_rw;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_out, mem_data_in;
  logic        load_valid, load_ready, load_last;
  logic [14:0] load_addr;
  logic [7:0]  load_data;
  logic        boot_done, err_oob, err_proto;
`ifdef MISAO_MEM_TRACE_EN
  logic [15:0] wr_count;
`endif

  always #5 clk = ~clk;

  misao_mem_responder #(.DEPTH(256), .AW(15), .LAST_WAIT(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_rw           (mem_rw),
    .mem_addr         (mem_addr),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .load_last        (load_last),
    .boot_done        (boot_done),
    .err_oob          (err_oob),
    .err_proto        (err_proto)
`ifdef MISAO_MEM_TRACE_EN
    ,
    .wr_count         (wr_count)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  wdat;
    logic [7:0]  exp_dat;
    logic        exp_oob;
    logic        exp_proto;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rd, logic wr, logic rw, logic [14:0] a,
                              logic [7:0] w, logic [7:0] e, logic o, logic p);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.addr = a;
    v.wdat = w; v.exp_dat = e; v.exp_oob = o; v.exp_proto = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b0;
    mem_enable_read = 1'b0; mem_enable_write = 1'b0; mem_rw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_data", 16'(mem_data_in), 16'h00);
    chk("rst_ready", 16'(load_ready), 16'd0);
    chk("rst_boot", 16'(boot_done), 16'd0);
    chk("rst_oob", 16'(err_oob), 16'd0);
    chk("rst_proto", 16'(err_proto), 16'd0);
    rst = 1'b1;
  endtask

  // Counts edges after reset release until load_ready rises (bounded).
  task automatic wait_clear();
    int cyc = 0;
    bit boot_seen = 1'b0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (boot_done) boot_seen = 1'b1;
      if (load_ready) break;
    end
    chk("clear_len", 16'(cyc), 16'd256);
    chk("clear_boot", 16'(boot_seen), 16'd0);
  endtask

  task automatic load_byte(input logic [14:0] a, input logic [7:0] d, input logic last);
    @(negedge clk);
    chk("load_rdy", 16'(load_ready), 16'd1);
    load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic rw,
                     input logic [14:0] a, input logic [7:0] w);
    @(negedge clk);
    mem_enable_read = rd; mem_enable_write = wr; mem_rw = rw;
    mem_addr = a; mem_data_out = w;
    @(posedge clk);
    @(negedge clk);
    mem_enable_read = 1'b0; mem_enable_write = 1'b0; mem_rw = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mem_enable_read = 1'b0; mem_enable_write = 1'b0; mem_rw = 1'b0;
    mem_addr = '0; mem_data_out = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;

    //            rd  wr  rw  addr      wdat   exp    oob proto
    vt.push_back(mk(1, 0, 0, 15'h0000, 8'h00, 8'h81, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h0001, 8'h00, 8'h0C, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h0002, 8'h00, 8'h34, 0, 0));
    vt.push_back(mk(0, 0, 0, 15'h0002, 8'h00, 8'h34, 0, 0));
    vt.push_back(mk(1, 1, 1, 15'h0010, 8'hA5, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h0010, 8'h00, 8'hA5, 0, 0));
    vt.push_back(mk(0, 1, 1, 15'h0020, 8'h5A, 8'hA5, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h0020, 8'h00, 8'h5A, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h00FF, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(0, 1, 1, 15'h00FF, 8'h77, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h00FF, 8'h00, 8'h77, 0, 0));
    vt.push_back(mk(1, 0, 0, 15'h0100, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(0, 1, 1, 15'h0100, 8'hEE, 8'h00, 1, 0));
    vt.push_back(mk(1, 0, 0, 15'h0000, 8'h00, 8'h81, 1, 0));
    vt.push_back(mk(1, 0, 0, 15'h7FFF, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(0, 1, 0, 15'h0030, 8'h3C, 8'h00, 1, 1));
    vt.push_back(mk(1, 0, 0, 15'h0030, 8'h00, 8'h3C, 1, 1));

    do_reset();
    wait_clear();

    // LOAD phase: CPU strobes see zero, writes dropped, no error flags.
    load_byte(15'h0000, 8'h81, 1'b0);
    chk("load_boot0", 16'(boot_done), 16'd0);
    load_byte(15'h0001, 8'h0C, 1'b0);
    cpu(1, 0, 0, 15'h0000, 8'h00);
    chk("ld_rd0", 16'(mem_data_in), 16'h00);
    cpu(0, 1, 0, 15'h0001, 8'hEE);
    cpu(1, 0, 0, 15'h0005, 8'h00);
    chk("ld_rd5", 16'(mem_data_in), 16'h00);
    cpu(1, 0, 1, 15'h0100, 8'h00);
    chk("ld_oob", 16'(err_oob), 16'd0);
    chk("ld_proto", 16'(err_proto), 16'd0);
    load_byte(15'h0002, 8'h34, 1'b1);
    chk("boot_after_last", 16'(boot_done), 16'd1);
    chk("ready_after_last", 16'(load_ready), 16'd0);

    // Loader traffic in RUN must be ignored (vec 0 rereads address 0).
    @(negedge clk);
    load_valid = 1'b1; load_addr = 15'h0000; load_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      cpu(vt[i].rd, vt[i].wr, vt[i].rw, vt[i].addr, vt[i].wdat);
      chk($sformatf("vec%0d_dat", i), 16'(mem_data_in), 16'(vt[i].exp_dat));
      chk($sformatf("vec%0d_oob", i), 16'(err_oob), 16'(vt[i].exp_oob));
      chk($sformatf("vec%0d_proto", i), 16'(err_proto), 16'(vt[i].exp_proto));
    end
    chk("run_boot", 16'(boot_done), 16'd1);
`ifdef MISAO_MEM_TRACE_EN
    chk("wr_count", wr_count, 16'd4);
`endif

    // Reset from RUN, then reset again mid-LOAD after one byte.
    do_reset();
    wait_clear();
    load_byte(15'h0000, 8'h11, 1'b0);
    do_reset();
    wait_clear();
    load_byte(15'h0101, 8'h22, 1'b1);
    chk("reload_boot", 16'(boot_done), 16'd1);
    cpu(1, 0, 0, 15'h0000, 8'h00);
    chk("reload_rd0", 16'(mem_data_in), 16'h00);
    cpu(1, 0, 0, 15'h0001, 8'h00);
    chk("reload_rd1", 16'(mem_data_in), 16'h22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
